// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises PLL lock, retries the PLL on lock timeout, and sequences
// the 74.25 MHz and 96 MHz reset releases. Define LOCK_STATS_EN to add the unlock_cnt statistic.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RST_CYC      = 27,
  parameter int LOCK_TIMEOUT_CYC = 2700000,
  parameter int LOCK_STABLE_CYC  = 2700,
  parameter int REL_GAP_CYC      = 16,
  parameter int CNT_W            = 22,
  parameter int RETRY_W          = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               pll_locked_in,
  output logic               pll_reset,
  output logic               rst74_n,
  output logic               rst96_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef LOCK_STATS_EN
  ,
  output logic [15:0]        unlock_cnt
`endif
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_VID   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(REL_GAP_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lk_s;
  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic [CNT_W-1:0]       cnt_s;
  logic [RETRY_W-1:0]     retry_s;
  logic                   lock_lost_s;
  logic                   pll_reset_s;
  logic                   rst74_n_s;
  logic                   rst96_n_s;

  assign lk_s = sync_r[SYNC_STAGES-1];

  // Lock synchroniser chain into the clk_in domain
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked_in};
    end
  end

  // Next-state, counter and retry logic; loss of lock outranks gap expiry
  always_comb begin
    state_s     = state_r;
    cnt_inc_s   = cnt_r + CNT_W'(1);
    retry_s     = retry_cnt;
    lock_lost_s = 1'b0;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == PLL_RST_LAST) begin
          state_s = WAIT_LOCK;
        end else begin
          state_s = PLL_RST;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_s = STABLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = PLL_RST;
          if (retry_cnt != {RETRY_W{1'b1}}) begin
            retry_s = retry_cnt + RETRY_W'(1);
          end else begin
            retry_s = retry_cnt;
          end
        end else begin
          state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_s = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = REL_VID;
        end else begin
          state_s = STABLE;
        end
      end
      REL_VID: begin
        if (!lk_s) begin
          state_s     = WAIT_LOCK;
          lock_lost_s = 1'b1;
        end else if (cnt_r == GAP_LAST) begin
          state_s = RUN;
        end else begin
          state_s = REL_VID;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_s     = WAIT_LOCK;
          lock_lost_s = 1'b1;
        end else begin
          state_s   = RUN;
          cnt_inc_s = cnt_r;
        end
      end
      default: begin
        state_s = PLL_RST;
      end
    endcase
    cnt_s       = (state_s != state_r) ? {CNT_W{1'b0}} : cnt_inc_s;
    pll_reset_s = (state_s == PLL_RST);
    rst74_n_s   = (state_s == REL_VID) || (state_s == RUN);
    rst96_n_s   = (state_s == RUN);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= PLL_RST;
      cnt_r     <= {CNT_W{1'b0}};
      pll_reset <= 1'b1;
      rst74_n   <= 1'b0;
      rst96_n   <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= {RETRY_W{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pll_reset <= pll_reset_s;
      rst74_n   <= rst74_n_s;
      rst96_n   <= rst96_n_s;
      ready     <= rst96_n_s;
      lock_lost <= lock_lost_s;
      retry_cnt <= retry_s;
    end
  end

`ifdef LOCK_STATS_EN
  // Saturating count of lock-loss events, cleared only by rst_n
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      unlock_cnt <= 16'h0000;
    end else if (lock_lost_s && (unlock_cnt != 16'hFFFF)) begin
      unlock_cnt <= unlock_cnt + 16'h0001;
    end else begin
      unlock_cnt <= unlock_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus pushes expected output changes with their
// cycle numbers; a negedge monitor pops and compares whenever the output vector changes.
module tb_pll_lock_supervisor;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       pll_locked_in;
  logic       pll_reset;
  logic       rst74_n;
  logic       rst96_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;
`ifdef LOCK_STATS_EN
  logic [15:0] unlock_cnt;
`endif

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  logic [8:0] prev_snap;
  logic [8:0] mon_cur;
  int         exp_cyc_q[$];
  logic [8:0] exp_snap_q[$];

  pll_lock_supervisor #(
    .SYNC_STAGES     (2),
    .PLL_RST_CYC     (4),
    .LOCK_TIMEOUT_CYC(50),
    .LOCK_STABLE_CYC (10),
    .REL_GAP_CYC     (3),
    .CNT_W           (22),
    .RETRY_W         (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .pll_locked_in(pll_locked_in),
    .pll_reset    (pll_reset),
    .rst74_n      (rst74_n),
    .rst96_n      (rst96_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .retry_cnt    (retry_cnt)
`ifdef LOCK_STATS_EN
    ,
    .unlock_cnt   (unlock_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [8:0] snap();
    return {pll_reset, rst74_n, rst96_n, ready, lock_lost, retry_cnt};
  endfunction

  function automatic logic [8:0] mk(input logic pr, input logic r74, input logic r96,
                                    input logic rdy, input logic ll, input int r);
    return {pr, r74, r96, rdy, ll, 4'(r)};
  endfunction

  task automatic push(input int c, input logic [8:0] s);
    exp_cyc_q.push_back(c);
    exp_snap_q.push_back(s);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every change of the output vector must match the next scoreboard entry
  always @(negedge clk_in) begin
    if (mon_en) begin
      mon_cur = snap();
      if (mon_cur !== prev_snap) begin
        checks++;
        if (exp_cyc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, mon_cur);
        end else begin
          int         ec;
          logic [8:0] es;
          ec = exp_cyc_q.pop_front();
          es = exp_snap_q.pop_front();
          if ((ec != cyc) || (es !== mon_cur)) begin
            errors++;
            $display("FAIL output_change got cyc=%0d {pr,74,96,rdy,ll,retry}=%b want cyc=%0d %b",
                     cyc, mon_cur, ec, es);
          end
        end
        prev_snap = mon_cur;
      end
    end
  end

  initial begin
    int r0, n0, m0, l0, g0, m2, f0, l3, r2;
    rst_n = 1'b1;
    pll_locked_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {7'd0, snap()}, {7'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)});
`ifdef LOCK_STATS_EN
    check("reset_unlock_cnt", unlock_cnt, 16'h0000);
`endif
    step(3);
    rst_n = 1'b1;
    r0 = cyc;
    prev_snap = snap();
    mon_en = 1'b1;
    push(r0 + 4, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));

    // Clean lock at cycle 20: release after 13 cycles, second domain 3 later
    step(20);
    n0 = cyc;
    pll_locked_in = 1'b1;
    push(n0 + 13, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    push(n0 + 16, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    step(30);

    // Lock loss in RUN: one-cycle lock_lost, all resets drop together
    m0 = cyc;
    pll_locked_in = 1'b0;
    push(m0 + 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    push(m0 + 4, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    step(10);

    // Re-lock, then lose lock on the cycle the release gap expires
    l0 = cyc;
    pll_locked_in = 1'b1;
    push(l0 + 13, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    step(13);
    pll_locked_in = 1'b0;
    push(l0 + 16, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    push(l0 + 17, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    step(4);

    // Glitch: 5 high, 1 low, then hold; stability count restarts
    g0 = cyc;
    pll_locked_in = 1'b1;
    step(5);
    pll_locked_in = 1'b0;
    step(1);
    pll_locked_in = 1'b1;
    push(g0 + 19, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    push(g0 + 22, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    step(30);

    // Lock lost for good: 20 retries every 54 cycles, retry_cnt saturates at 15
    m2 = cyc;
    pll_locked_in = 1'b0;
    push(m2 + 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    push(m2 + 4, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    for (int k = 1; k <= 20; k++) begin
      int t;
      int r;
      t = m2 + 53 + 54 * (k - 1);
      r = (k > 15) ? 15 : k;
      push(t,     mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r));
      push(t + 4, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r));
    end
    step(210);
    check("retry_cnt_after_200", {12'd0, retry_cnt}, 16'd3);
    f0 = m2 + 57 + 54 * 19;
    step(f0 + 5 - cyc);

    // Re-lock with saturated retry count, then async reset mid-run
    l3 = cyc;
    pll_locked_in = 1'b1;
    push(l3 + 13, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15));
    push(l3 + 16, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15));
    step(25);
`ifdef LOCK_STATS_EN
    check("unlock_cnt_three", unlock_cnt, 16'd3);
`endif
    #2;
    push(cyc, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {7'd0, snap()}, {7'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)});
`ifdef LOCK_STATS_EN
    check("async_reset_unlock_cnt", unlock_cnt, 16'h0000);
`endif
    step(1);
    rst_n = 1'b1;
    r2 = cyc;
    push(r2 + 4,  mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    push(r2 + 15, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    push(r2 + 18, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    step(30);

    check("scoreboard_drained", 16'(exp_cyc_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
